// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake; y == 0 short-circuits to a flagged result.
module seq_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] rem;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   t;
   logic [WIDTH-1:0] low;
   logic             c_low;
   logic             carry;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] dvd_next;

   // Trial subtraction t + ~{0,y} + 1. The top bit of t only feeds the carry,
   // so the partial remainder (always < y) is stored in WIDTH bits.
   always_comb begin
      t              = {rem, dvd[WIDTH-1]};
      {c_low, low}   = {1'b0, t[WIDTH-1:0]} + {1'b0, ~dvs} + (WIDTH+1)'(1);
      carry          = t[WIDTH] | c_low;
      rem_next       = carry ? low : t[WIDTH-1:0];
      dvd_next       = {dvd[WIDTH-2:0], carry};
   end

   // NOTE: state and outputs are registers, so every assignment here is
   // non-blocking; rst is tested first and wins over any other activity.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         q           <= '0;
         r           <= '0;
         div_by_zero <= 1'b0;
         dvd         <= '0;
         dvs         <= '0;
         rem         <= '0;
         cnt         <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (y != '0) begin
                     dvd         <= x;
                     dvs         <= y;
                     rem         <= '0;
                     div_by_zero <= 1'b0;
                     cnt         <= CW'(WIDTH - 1);
                     busy        <= 1'b1;
                     state       <= CALC;
                  end else begin
                     q           <= '1;
                     r           <= x;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     state       <= DONE;
                  end
               end
            end
            CALC: begin
               rem <= rem_next;
               dvd <= dvd_next;
               if (cnt == '0) begin
                  // Publish the final step directly so results appear with done.
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  q     <= dvd_next;
                  r     <= rem_next;
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4): vector table, corner-case
// sequences and an exhaustive sweep, all scored through an expected-result queue.
module tb_seq_divider;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] x, y;
   logic         busy, done, div_by_zero;
   logic [W-1:0] q, r;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } exp_t;

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      int           inj;
   } vec_t;

   exp_t sb[$];

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .x           (x),
      .y           (y),
      .busy        (busy),
      .done        (done),
      .q           (q),
      .r           (r),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drives one operation; inj>0 drives a stray start (x=1,y=1) on that cycle.
   task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ed, input int inj);
      int   lat      = 0;
      int   busy_cnt = 0;
      int   exp_lat;
      exp_t e;
      exp_lat = (yv == '0) ? 1 : W + 1;
      @(negedge clk);
      x     = xv;
      y     = yv;
      start = 1'b1;
      sb.push_back('{q: eq, r: er, dbz: ed});
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == inj) begin
            start = 1'b1;
            x     = 4'd1;
            y     = 4'd1;
         end
         if (k == inj + 1) start = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin
            lat = k;
            break;
         end
      end
      if (lat == 0) begin
         check("done_timeout", 32'd0, 32'd1);
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         check("q", q, e.q);
         check("r", r, e.r);
         check("div_by_zero", div_by_zero, e.dbz);
         check("latency", lat, exp_lat);
         check("busy_cycles", busy_cnt, exp_lat - 1);
         @(negedge clk);
         start = 1'b0;
         check("done_one_cycle", done, 1'b0);
         check("q_hold", q, e.q);
         @(negedge clk);
         check("idle_after_done", {busy, done}, 2'b00);
      end
   endtask

   initial begin
      vec_t vecs[7];
      vecs[0] = '{x: 13, y: 4, q: 3,  r: 1, dbz: 0, inj: 0};
      vecs[1] = '{x: 15, y: 1, q: 15, r: 0, dbz: 0, inj: 0};
      vecs[2] = '{x: 3,  y: 7, q: 0,  r: 3, dbz: 0, inj: 0};
      vecs[3] = '{x: 0,  y: 5, q: 0,  r: 0, dbz: 0, inj: 0};
      vecs[4] = '{x: 9,  y: 0, q: 15, r: 9, dbz: 1, inj: 0};
      vecs[5] = '{x: 14, y: 3, q: 4,  r: 2, dbz: 0, inj: 2};
      vecs[6] = '{x: 6,  y: 2, q: 3,  r: 0, dbz: 0, inj: 5};

      rst   = 1'b1;
      start = 1'b0;
      x     = '0;
      y     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_q", q, 4'd0);
      check("reset_r", r, 4'd0);
      check("reset_dbz", div_by_zero, 1'b0);

      foreach (vecs[i])
         run_op(vecs[i].x, vecs[i].y, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].inj);

      // Abort mid-CALC: previous result (q=3) must be cleared and no done issued.
      @(negedge clk);
      x     = 4'd10;
      y     = 4'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("abort_busy_before", busy, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_outputs", {busy, done, div_by_zero, q, r}, 11'd0);
      begin
         int seen = 0;
         repeat (8) begin
            @(negedge clk);
            if (done || busy) seen++;
         end
         check("abort_no_done", seen, 0);
      end
      run_op(4'd10, 4'd2, 4'd5, 4'd0, 1'b0, 0);

      for (int xi = 0; xi < 16; xi++) begin
         for (int yi = 0; yi < 16; yi++) begin
            if (yi == 0)
               run_op(4'(xi), 4'd0, 4'd15, 4'(xi), 1'b1, 0);
            else
               run_op(4'(xi), 4'(yi), 4'(xi / yi), 4'(xi % yi), 1'b0, 0);
         end
      end

      check("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
